// File: rtl/mult_arbiter4.sv
// Four-way round-robin arbiter with lock, feeding one shared pipelined
// 18x18 multiplier and routing each product back to its issuing requester.
module mult_arbiter4 #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [18*NREQ-1:0]   req_a,
    input  logic [18*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [17:0]          mul_op_a,
    output logic [17:0]          mul_op_b,
    input  logic [35:0]          mul_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [35:0]          rsp_data,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] gidx;
    logic          found;
    logic          xfer;

    logic [LAT-1:0] pv;
    logic [IW-1:0]  pid [LAT];

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + IW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    assign xfer = found & en & reset_n;

    always_comb begin
        req_ready = '0;
        mul_op_a  = '0;
        mul_op_b  = '0;
        if (xfer) begin
            req_ready = NREQ'(1) << gidx;
            mul_op_a  = req_a[18*gidx +: 18];
            mul_op_b  = req_b[18*gidx +: 18];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= req_lock[gidx] ? gidx : gidx + IW'(1);
        end
    end

    // Tag pipeline tracks the multiplier latency; it never stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            for (int k = 0; k < LAT; k++) begin
                pid[k] <= '0;
            end
        end else begin
            pv[0]  <= xfer;
            pid[0] <= gidx;
            for (int k = 1; k < LAT; k++) begin
                pv[k]  <= pv[k-1];
                pid[k] <= pid[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (pv[LAT-1]) begin
            rsp_valid = NREQ'(1) << pid[LAT-1];
            rsp_data  = mul_result;
        end
    end

    assign busy = |pv;

endmodule

// File: tb/tb_mult_arbiter4.sv
// Bench for mult_arbiter4: directed vector table, then random traffic
// compared against a cycle-indexed behavioural model.
module tb_mult_arbiter4;

    localparam int MAXC = 4096;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [71:0] req_a;
    logic [71:0] req_b;
    logic [3:0]  req_ready;
    logic [17:0] mul_op_a;
    logic [17:0] mul_op_b;
    logic [35:0] mul_result;
    logic [3:0]  rsp_valid;
    logic [35:0] rsp_data;
    logic        busy;

    mult_arbiter4 #(.NREQ(4), .LAT(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .en(en),
        .req_valid(req_valid),
        .req_lock(req_lock),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .mul_op_a(mul_op_a),
        .mul_op_b(mul_op_b),
        .mul_result(mul_result),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    // Stand-in two-stage multiplier; deliberately not reset.
    logic [35:0] p1, p2;
    always @(posedge clk) begin
        p1 <= 36'(mul_op_a) * 36'(mul_op_b);
        p2 <= p1;
    end
    assign mul_result = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic [17:0] a;
        logic [17:0] b;
        bit          rst;
        logic [3:0]  ready;
        logic [3:0]  rsp;
        logic [35:0] data;
        bit          busy;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mptr = 0;
    int mg = -1;
    bit          ev   [MAXC];
    int          eid  [MAXC];
    logic [35:0] edat [MAXC];

    function automatic vec_t mk(bit e, logic [3:0] v, logic [3:0] l,
                                logic [17:0] a, logic [17:0] b, bit r,
                                logic [3:0] rdy, logic [3:0] rv,
                                logic [35:0] d, bit bz);
        vec_t t;
        t.en = e; t.valid = v; t.lock = l; t.a = a; t.b = b; t.rst = r;
        t.ready = rdy; t.rsp = rv; t.data = d; t.busy = bz;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic clear_future();
        for (int k = cyc; k < MAXC; k++) ev[k] = 1'b0;
    endtask

    // Expected outputs derived from the arbitration rules, sampled at negedge.
    task automatic model_check();
        logic [3:0]  er, erv;
        logic [17:0] ea, eb;
        logic [35:0] ed;
        logic        ebz;
        int          i;
        mg = -1;
        er = '0; erv = '0; ea = '0; eb = '0; ed = '0; ebz = 1'b0;
        if (!reset_n) begin
            clear_future();
        end else begin
            if (en) begin
                for (int k = 0; k < 4; k++) begin
                    i = (mptr + k) % 4;
                    if (mg < 0 && req_valid[i]) mg = i;
                end
            end
            if (mg >= 0) begin
                er = 4'(1 << mg);
                ea = req_a[18*mg +: 18];
                eb = req_b[18*mg +: 18];
            end
            if (ev[cyc]) begin
                erv = 4'(1 << eid[cyc]);
                ed  = edat[cyc];
            end
            ebz = ev[cyc] || ev[cyc+1];
        end
        check("m_ready", 64'(req_ready), 64'(er));
        check("m_op_a", 64'(mul_op_a), 64'(ea));
        check("m_op_b", 64'(mul_op_b), 64'(eb));
        check("m_rsp_valid", 64'(rsp_valid), 64'(erv));
        check("m_rsp_data", 64'(rsp_data), 64'(ed));
        check("m_busy", 64'(busy), 64'(ebz));
    endtask

    task automatic model_update();
        if (!reset_n) begin
            mptr = 0;
            clear_future();
        end else if (mg >= 0) begin
            ev[cyc+2]   = 1'b1;
            eid[cyc+2]  = mg;
            edat[cyc+2] = 36'(req_a[18*mg +: 18]) * 36'(req_b[18*mg +: 18]);
            mptr = req_lock[mg] ? mg : (mg + 1) % 4;
        end
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic run_cycle(bit rst, bit has_exp, vec_t t, int row);
        if (rst) begin
            #1 reset_n = 1'b0;
        end
        @(negedge clk);
        model_check();
        if (has_exp) begin
            check($sformatf("t%0d_ready", row), 64'(req_ready), 64'(t.ready));
            check($sformatf("t%0d_rsp_valid", row), 64'(rsp_valid), 64'(t.rsp));
            check($sformatf("t%0d_rsp_data", row), 64'(rsp_data), 64'(t.data));
            check($sformatf("t%0d_busy", row), 64'(busy), 64'(t.busy));
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        if (rst) reset_n = 1'b1;
    endtask

    task automatic do_reset();
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        en = 1'b0; req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;
        run_cycle(0, 1, z, -1);
        run_cycle(0, 1, z, -1);
        reset_n = 1'b1;
    endtask

    int seg2;

    initial begin
        reset_n = 1'b0;
        en = 1'b0; req_valid = '0; req_lock = '0; req_a = '0; req_b = '0;

        // Fairness, en drop, max operands, lock.
        tbl.push_back(mk(1, 4'b1111, 0, 3, 5, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 2, 7, 0, 4'b0010, 0, 0, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 4, 4, 0, 4'b0100, 4'b0001, 15, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 6, 1, 0, 4'b1000, 4'b0010, 14, 1));
        tbl.push_back(mk(1, 4'b1111, 0, 18'h3FFFF, 18'h3FFFF, 0,
                         4'b0001, 4'b0100, 16, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 1, 0, 0, 4'b1000, 6, 1));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0001,
                         36'hFFFF80001, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 4'b0010, 1, 1, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0110, 4'b0010, 2, 3, 0, 4'b0010, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0110, 0, 5, 5, 0, 4'b0010, 4'b0010, 1, 1));
        tbl.push_back(mk(1, 4'b0110, 0, 7, 7, 0, 4'b0100, 4'b0010, 6, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0010, 25, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0100, 49, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        seg2 = tbl.size();
        // Single request, then reset mid-flight and first grant after it.
        tbl.push_back(mk(1, 4'b0001, 0, 3, 5, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 15, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 9, 9, 0, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 9, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'b1111, 0, 9, 9, 0, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 81, 1));

        #1;
        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            if (r == seg2) do_reset();
            en        = tbl[r].en;
            req_valid = tbl[r].valid;
            req_lock  = tbl[r].lock;
            req_a     = {4{tbl[r].a}};
            req_b     = {4{tbl[r].b}};
            run_cycle(tbl[r].rst, 1, tbl[r], r);
        end

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            vec_t z;
            bit   rst;
            z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            en        = ($urandom % 8) != 0;
            req_valid = 4'($urandom);
            req_lock  = 4'($urandom & $urandom);
            req_a     = {8'($urandom), $urandom, $urandom};
            req_b     = {8'($urandom), $urandom, $urandom};
            if ($urandom % 8 == 0) req_a = {72{1'b1}};
            if ($urandom % 8 == 0) req_b = {72{1'b1}};
            rst = ($urandom % 64) == 0;
            run_cycle(rst, 0, z, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
